// File: rtl/cpack_decompressor_if.sv
// Stream-side bus of the C-Pack decompressor: compressed beats in,
// decompressed words out, plus line/error status and an FSM debug tap.
//
// Handshake: a transfer happens on a rising clock edge where valid and
// ready are both high. Once valid is raised its data stays stable until
// the transfer completes. Ready may depend on valid; valid never depends
// on ready.
interface cpack_decompressor_if #(
  parameter int WIDTH = 64,
  parameter int WORD  = 32
);
  logic [WIDTH-1:0] i_data;
  logic             i_valid;
  logic             o_ready;
  logic [WORD-1:0]  o_word;
  logic             o_valid;
  logic             i_ready;
  logic             o_line_done;
  logic             o_error;
  logic [1:0]       dbg_state;

  // Decompressor side
  modport slave (
    input  i_data, i_valid, i_ready,
    output o_ready, o_word, o_valid, o_line_done, o_error, dbg_state
  );

  // Stream source / word consumer side
  modport master (
    output i_data, i_valid, i_ready,
    input  o_ready, o_word, o_valid, o_line_done, o_error, dbg_state
  );
endinterface

// File: rtl/cpack_decompressor.sv
// C-Pack decompressor: parses MSB-first variable-length codes out of a
// 128-bit left-aligned bit buffer, rebuilds 32-bit words against a local
// FIFO dictionary and emits one word per cycle. Each 128-bit line (four
// words) is followed by padding up to the next 64-bit beat boundary, which
// is dropped in S_FLUSH together with the dictionary contents.
module cpack_decompressor #(
  parameter int WIDTH      = 64,
  parameter int WORD       = 32,
  parameter int DICT_ENTRY = 16,
  parameter int CACHE_LINE = 128
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  cpack_decompressor_if.slave  bus
);

  localparam int BUF_W      = 2 * WIDTH;
  localparam int LINE_WORDS = CACHE_LINE / WORD;
  localparam int CNT_W      = $clog2(LINE_WORDS);
  localparam int PTR_W      = $clog2(DICT_ENTRY);

  typedef enum logic [1:0] {
    S_DECODE = 2'd0,
    S_FLUSH  = 2'd1,
    S_ERR    = 2'd2
  } state_t;

  state_t state, state_next;

  logic [BUF_W-1:0] sbuf;          // left-aligned; bits below count are zero
  logic [7:0]       count;
  logic [5:0]       consumed;      // bits consumed in this line, mod 64
  logic [CNT_W-1:0] word_cnt;
  logic [WORD-1:0]  dict [DICT_ENTRY];
  logic [PTR_W-1:0] wr_ptr;
  logic [WORD-1:0]  word_q;
  logic             valid_q;
  logic             last_q;

  // Code decoder outputs
  logic [7:0]       len;
  logic [WORD-1:0]  dec_word;
  logic             dec_push;
  logic             illegal;
  logic             resolvable;
  logic             stall;

  // FSM outputs
  logic             fire;
  logic             flush;
  logic [7:0]       shamt;

  // Buffer datapath
  logic             accept;
  logic [7:0]       count_after;
  logic [BUF_W-1:0] buf_shift;
  logic [BUF_W-1:0] beat_aligned;
  logic [5:0]       pad;

  logic [PTR_W-1:0] idx_m;
  logic [PTR_W-1:0] idx_l;

  assign idx_m = sbuf[BUF_W-3 -: PTR_W];
  assign idx_l = sbuf[BUF_W-5 -: PTR_W];
  assign pad   = 6'd0 - consumed;
  assign stall = valid_q && !bus.i_ready;
  // 2-bit prefixes need only 2 buffered bits; 11xx needs all four.
  assign resolvable = (count >= 8'd4) ||
                      ((count >= 8'd2) && (sbuf[BUF_W-1 -: 2] != 2'b11));

  // Decode the code at the head of the buffer: length, word, dictionary push
  always_comb begin
    len      = 8'd0;
    dec_word = '0;
    dec_push = 1'b0;
    illegal  = 1'b0;
    case (sbuf[BUF_W-1 -: 2])
      2'b00: begin
        len = 8'd2;
      end
      2'b01: begin
        len      = 8'd34;
        dec_word = sbuf[BUF_W-3 -: WORD];
        dec_push = 1'b1;
      end
      2'b10: begin
        len      = 8'd6;
        dec_word = dict[idx_m];
      end
      default: begin
        case (sbuf[BUF_W-3 -: 2])
          2'b00: begin
            len      = 8'd24;
            dec_word = {dict[idx_l][WORD-1:16], sbuf[BUF_W-9 -: 16]};
            dec_push = 1'b1;
          end
          2'b01: begin
            len      = 8'd12;
            dec_word = {24'h0, sbuf[BUF_W-5 -: 8]};
          end
          2'b10: begin
            len      = 8'd16;
            dec_word = {dict[idx_l][WORD-1:8], sbuf[BUF_W-9 -: 8]};
            dec_push = 1'b1;
          end
          default: begin
            illegal = 1'b1;
          end
        endcase
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge i_clk) begin
    if (i_reset) state <= S_DECODE;
    else         state <= state_next;
  end

  // FSM next state and per-cycle consume amount
  always_comb begin
    state_next = state;
    fire       = 1'b0;
    flush      = 1'b0;
    shamt      = 8'd0;
    case (state)
      S_DECODE: begin
        if (resolvable) begin
          if (illegal) begin
            state_next = S_ERR;
          end else if ((count >= len) && !stall) begin
            fire  = 1'b1;
            shamt = len;
            if (word_cnt == CNT_W'(LINE_WORDS - 1)) state_next = S_FLUSH;
          end
        end
      end
      S_FLUSH: begin
        flush      = 1'b1;
        shamt      = {2'b00, pad};
        state_next = S_DECODE;
      end
      S_ERR: begin
        state_next = S_ERR;
      end
      default: begin
        state_next = S_DECODE;
      end
    endcase
  end

  // Consume shift first, then place an accepted beat right after what remains
  assign accept       = bus.i_valid && bus.o_ready;
  assign count_after  = count - shamt;
  assign buf_shift    = sbuf << shamt;
  assign beat_aligned = {bus.i_data, {WIDTH{1'b0}}} >> count_after;

  // Bit buffer, dictionary, line bookkeeping and registered output word
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      sbuf     <= '0;
      count    <= 8'd0;
      consumed <= 6'd0;
      word_cnt <= '0;
      wr_ptr   <= '0;
      word_q   <= '0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      for (int i = 0; i < DICT_ENTRY; i++) dict[i] <= '0;
    end else begin
      sbuf  <= accept ? (buf_shift | beat_aligned) : buf_shift;
      count <= count_after + (accept ? 8'd64 : 8'd0);
      if (fire) begin
        consumed <= consumed + len[5:0];
        word_cnt <= word_cnt + 1'b1;
        word_q   <= dec_word;
        valid_q  <= 1'b1;
        last_q   <= (word_cnt == CNT_W'(LINE_WORDS - 1));
        if (dec_push) begin
          dict[wr_ptr] <= dec_word;
          wr_ptr       <= wr_ptr + 1'b1;
        end
      end else if (bus.i_ready || (state_next == S_ERR)) begin
        valid_q <= 1'b0;
      end
      if (flush) begin
        consumed <= 6'd0;
        word_cnt <= '0;
        wr_ptr   <= '0;
        for (int i = 0; i < DICT_ENTRY; i++) dict[i] <= '0;
      end
    end
  end

  assign bus.o_ready     = (count <= 8'd64) && (state != S_ERR);
  assign bus.o_word      = word_q;
  assign bus.o_valid     = valid_q;
  assign bus.o_line_done = valid_q && bus.i_ready && last_q;
  assign bus.o_error     = (state == S_ERR);
  assign bus.dbg_state   = state;

endmodule

// File: tb/tb_cpack_decompressor.sv
// Bench for cpack_decompressor. Lines are described as lists of codes; a
// reference model turns each code into its bit pattern and expected word
// (tracking its own dictionary), packs the line into 64-bit beats and
// pushes the expected words into exp_q. A driver streams the beats, a
// consumer toggles i_ready and a monitor pops/compares every handshake.
module tb_cpack_decompressor;

  logic clk;
  logic i_reset;

  cpack_decompressor_if bus ();

  cpack_decompressor dut (
    .i_clk   (clk),
    .i_reset (i_reset),
    .bus     (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [32:0] exp_q[$];      // {last_of_line, word}
  logic [63:0] beat_q[$];
  bit          bq[$];         // bits of the line being built
  logic [31:0] m_dict [16];
  int          m_wr;
  int          m_n;

  bit rst_req    = 1'b0;
  int rst_cnt    = 0;
  int pop_cnt    = 0;
  bit acc_pend   = 1'b0;
  bit force_lo   = 1'b0;
  bit rand_ready = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  task automatic model_clear();
    for (int i = 0; i < 16; i++) m_dict[i] = 32'h0;
    m_wr = 0;
    m_n  = 0;
    bq.delete();
  endtask

  task automatic push_bits(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) bq.push_back(v[i]);
  endtask

  // t: 0 zzzz, 1 xxxx, 2 mmmm, 3 mmxx, 4 zzzx, 5 mmmx
  task automatic add_code(input int t, input int idx, input logic [31:0] p);
    logic [31:0] w;
    logic [31:0] d;
    logic [63:0] beat;
    bit          push;
    d    = m_dict[idx];
    push = 1'b0;
    w    = 32'h0;
    case (t)
      0: begin push_bits(32'h0, 2); end
      1: begin w = p; push_bits(32'h1, 2); push_bits(p, 32); push = 1'b1; end
      2: begin w = d; push_bits(32'h2, 2); push_bits(32'(idx), 4); end
      3: begin
        w = {d[31:16], p[15:0]};
        push_bits(32'hC, 4); push_bits(32'(idx), 4); push_bits(p, 16); push = 1'b1;
      end
      4: begin w = {24'h0, p[7:0]}; push_bits(32'hD, 4); push_bits(p, 8); end
      default: begin
        w = {d[31:8], p[7:0]};
        push_bits(32'hE, 4); push_bits(32'(idx), 4); push_bits(p, 8); push = 1'b1;
      end
    endcase
    if (push) begin
      m_dict[m_wr] = w;
      m_wr = (m_wr + 1) % 16;
    end
    exp_q.push_back({(m_n == 3), w});
    m_n++;
    if (m_n == 4) begin
      while (bq.size() % 64 != 0) bq.push_back(1'b0);
      while (bq.size() > 0) begin
        for (int i = 63; i >= 0; i--) beat[i] = bq.pop_front();
        beat_q.push_back(beat);
      end
      model_clear();
    end
  endtask

  task automatic add_plan_line();
    add_code(1, 0, 32'hDEADBEEF);
    add_code(2, 0, 32'h0);
    add_code(4, 0, 32'h5A);
    add_code(5, 0, 32'h11);
  endtask

  task automatic add_zero_line();
    for (int k = 0; k < 4; k++) add_code(0, 0, 32'h0);
  endtask

  task automatic add_random_line();
    for (int k = 0; k < 4; k++)
      add_code($urandom_range(0, 5), $urandom_range(0, 15), $urandom);
  endtask

  // ---------------- driver tasks ----------------
  always @(negedge clk) acc_pend = bus.i_valid && bus.o_ready && !i_reset;

  initial begin
    i_reset     = 1'b1;
    bus.i_valid = 1'b0;
    bus.i_data  = 64'h0;
    forever begin
      @(posedge clk);
      #1;
      if (i_reset) i_reset = 1'b0;
      if (acc_pend) void'(beat_q.pop_front());
      if (rst_req) begin
        i_reset     = 1'b1;
        bus.i_valid = 1'b0;
        beat_q.delete();
        exp_q.delete();
        rst_req = 1'b0;
        rst_cnt++;
      end else if (!bus.i_valid || acc_pend) begin
        if (beat_q.size() > 0 && (!rand_ready || $urandom_range(0, 3) != 0)) begin
          bus.i_valid = 1'b1;
          bus.i_data  = beat_q[0];
        end else begin
          bus.i_valid = 1'b0;
        end
      end
    end
  end

  initial begin
    bus.i_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (force_lo)        bus.i_ready = 1'b0;
      else if (rand_ready) bus.i_ready = ($urandom_range(0, 3) != 0);
      else                 bus.i_ready = 1'b1;
    end
  end

  task automatic do_reset();
    int old;
    int t;
    old = rst_cnt;
    rst_req = 1'b1;
    t = 0;
    while (rst_cnt == old && t < 20) begin @(negedge clk); t++; end
    if (rst_cnt == old) begin
      n_checks++; n_errors++;
      $display("FAIL reset_req: got timeout expected reset issued");
    end
    @(negedge clk);
    model_clear();
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    while ((exp_q.size() != 0 || beat_q.size() != 0) && t < 5000) begin
      @(negedge clk); t++;
    end
    check({name, "_drain_left"}, exp_q.size(), 0);
    repeat (4) @(negedge clk);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [32:0] e;
    if (!i_reset && bus.o_valid === 1'b1 && bus.i_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++; n_errors++;
        $display("FAIL unexpected_word: got %h expected no output", bus.o_word);
      end else begin
        e = exp_q.pop_front();
        check("word", bus.o_word, e[31:0]);
        check("line_done", bus.o_line_done, e[32]);
      end
      pop_cnt++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    logic [31:0] hold_exp;
    int          t;
    int          run;
    int          base;

    model_clear();
    repeat (2) @(negedge clk);
    do_reset();
    check("rst_o_valid", bus.o_valid, 0);
    check("rst_o_line_done", bus.o_line_done, 0);
    check("rst_o_error", bus.o_error, 0);
    check("rst_o_word", bus.o_word, 0);
    check("rst_o_ready", bus.o_ready, 1);
    check("rst_state", bus.dbg_state, 0);

    // four zero codes in a single beat
    add_zero_line();
    drain("zero_line");
    check("zero_state", bus.dbg_state, 0);
    check("zero_ready", bus.o_ready, 1);

    // mixed line across two beats, then a line reading dict[0] after clear
    add_plan_line();
    add_code(2, 0, 32'h0);
    for (int k = 0; k < 3; k++) add_code(0, 0, 32'h0);
    drain("plan_line");

    // output stall: first word held for five cycles
    force_lo = 1'b1;
    add_plan_line();
    hold_exp = exp_q[0][31:0];
    t = 0;
    while (bus.o_valid !== 1'b1 && t < 50) begin @(negedge clk); t++; end
    check("hold_first_valid", bus.o_valid, 1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("hold_valid", bus.o_valid, 1);
      check("hold_word", bus.o_word, hold_exp);
    end
    force_lo = 1'b0;
    @(negedge clk);
    run = 0;
    while (bus.o_valid === 1'b1 && run < 8) begin run++; @(negedge clk); end
    check("b2b_run", run, 4);
    drain("hold_line");

    // reset after the second word of a line
    base = pop_cnt;
    add_plan_line();
    t = 0;
    while (pop_cnt < base + 2 && t < 200) begin @(negedge clk); t++; end
    check("midreset_words_seen", (pop_cnt >= base + 2), 1);
    do_reset();
    check("midreset_o_valid", bus.o_valid, 0);
    check("midreset_o_ready", bus.o_ready, 1);
    add_zero_line();
    drain("after_reset");

    // illegal prefix
    beat_q.push_back(64'hF000_0000_0000_0000);
    t = 0;
    while (bus.o_error !== 1'b1 && t < 30) begin @(negedge clk); t++; end
    check("err_flag", bus.o_error, 1);
    @(negedge clk);
    check("err_ready", bus.o_ready, 0);
    check("err_valid", bus.o_valid, 0);
    check("err_state", bus.dbg_state, 2);
    repeat (3) @(negedge clk);
    check("err_sticky", bus.o_error, 1);
    do_reset();
    check("err_clr_flag", bus.o_error, 0);
    check("err_clr_ready", bus.o_ready, 1);
    add_plan_line();
    drain("after_err");

    // randomized lines with random source gaps and consumer back-pressure
    rand_ready = 1'b1;
    for (int l = 0; l < 40; l++) add_random_line();
    drain("random");
    rand_ready = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/cpack_decompressor.md
Name: cpack_decompressor

Overview:
- Receive-side counterpart of the two-word C-Pack compression front end (stage1and2).
- Takes the compressed bitstream in 64-bit beats and parses the variable-length codes MSB-first.
- Rebuilds each 32-bit word using a local 16-entry FIFO dictionary that tracks the compressor's update rules.
- Emits one decompressed word per cycle with a valid/ready handshake and flags the end of each 128-bit cache line.

Parameters:
- WIDTH, 64, input beat width in bits.
- WORD, 32, decompressed word width.
- DICT_ENTRY, 16, dictionary depth. Index field is 4 bits.
- CACHE_LINE, 128, line size in bits. Words per line = CACHE_LINE/WORD = 4.

Ports:
- i_clk  in  1  clock.
- i_reset  in  1  reset. One clock; reset is synchronous and active-high.
- i_data  in  WIDTH  compressed beat; bit 63 is first in the stream.
- i_valid  in  1  i_data valid.
- o_ready  out  1  beat accepted when i_valid && o_ready.
- o_word  out  WORD  decompressed word.
- o_valid  out  1  o_word valid.
- i_ready  in  1  consumer accepts o_word when o_valid && i_ready.
- o_line_done  out  1  one-cycle pulse, coincident with the handshake of a line's 4th word.
- o_error  out  1  sticky; illegal prefix detected.

Behaviour:
- Codes, prefix then payload, MSB first:
  - zzzz = 00, length 2, word 0.
  - xxxx = 01 + 32-bit word, length 34.
  - mmmm = 10 + idx4, length 6, word dict[idx].
  - mmxx = 1100 + idx4 + 16 bits, length 24, word {dict[idx][31:16], payload}.
  - zzzx = 1101 + 8 bits, length 12, word {24'h0, payload}.
  - mmmx = 1110 + idx4 + 8 bits, length 16, word {dict[idx][31:8], payload}.
  - 1111 is illegal.
- Dictionary push:
  - xxxx, mmxx and mmmx push the decoded word at wr_ptr; wr_ptr increments mod 16.
  - zzzz, zzzx and mmmm do not push.
  - idx addresses the physical entry. Unwritten entries read 0.
  - At each line start, all 16 entries and wr_ptr clear to 0, so lines decode independently.
- Bit buffer:
  - 128-bit shift buffer, left-aligned; count is 0..128 (8 bits).
  - o_ready = (count <= 64) && state != S_ERR.
  - An accepted beat appends at bit position count.
  - Accept and consume may occur in the same cycle. The append is positioned after the consume shift.
- FSM states: S_DECODE, S_FLUSH, S_ERR.
- S_DECODE:
  - Decoding needs count >= 4, or count >= 2 with a 00/01/10 prefix, so the prefix is resolvable.
  - It also needs count >= the full code length, and no output stall (o_valid==0 or i_ready==1).
  - Each decode consumes the code length, updates consumed_mod64, and registers o_word/o_valid on the next edge. Decode-to-output latency is 1 cycle.
  - Back-to-back decodes give one word per cycle.
  - A word counter (2 bits) increments on each decode. After the 4th decode, go to S_FLUSH.
- S_FLUSH:
  - Discard pad = (64 - consumed_mod64) mod 64 bits. These bits are always already buffered.
  - Clear the dictionary, the word counter and consumed_mod64, then return to S_DECODE.
  - Takes 1 cycle.
- Output hold: while o_valid && !i_ready, o_word is stable and no new decode starts.
- Illegal prefix 1111:
  - Go to S_ERR. o_error=1, o_ready=0, o_valid=0.
  - Stays there until i_reset.
- Reset:
  - o_valid=0, o_line_done=0, o_error=0, o_word=0, o_ready=1 after reset.
  - count=0, dictionary=0, wr_ptr=0, word counter=0, state=S_DECODE.
  - Reset asserted mid-line discards all buffered bits and any pending output in the same cycle.
  - Reset has priority over every handshake.

Test Plan:
- Four zzzz (beat 64'h0): outputs 0,0,0,0. o_line_done on the 4th. 56 pad bits dropped. count=0 after S_FLUSH.
- Stream xxxx DEADBEEF, mmmm idx0, zzzx 5A, mmmx idx0 payload 11 (68 bits over 2 beats, zero padded): outputs DEADBEEF, DEADBEEF, 0000005A, DEADBE11. dict[1]=DEADBE11.
- Second line mmmm idx0 right after the previous one: output 00000000, confirming the dictionary clear at the line boundary.
- Hold i_ready=0 for 5 cycles after the first o_valid: o_word stable, no further decode. The remaining words emerge back-to-back on release.
- Beat starting with 1111: o_error=1 next cycle, o_ready=0, no o_valid. i_reset=1 for 1 cycle clears it.
- Assert i_reset after the 2nd word of a line: o_valid=0 next cycle. A fresh line of four zzzz then decodes correctly.
